// File: rtl/gerenciador_sequencia_param_pkg.sv
// rtl/gerenciador_sequencia_param_pkg.sv - state codes and mode constants for the sequence engine
package gerenciador_sequencia_param_pkg;

    typedef enum logic [3:0] {
        OCIOSO         = 4'h0,
        GRAVA          = 4'h1,
        MOSTRA_ACESO   = 4'h2,
        MOSTRA_APAGADO = 4'h3,
        CONFERE        = 4'h4,
        FIM            = 4'hF
    } estado_t;

    localparam logic [1:0] MODO_NENHUM   = 2'b00;
    localparam logic [1:0] MODO_GRAVAR   = 2'b01;
    localparam logic [1:0] MODO_MOSTRAR  = 2'b10;
    localparam logic [1:0] MODO_CONFERIR = 2'b11;

endpackage

// File: rtl/gerenciador_sequencia_param_contador_tempo.sv
// rtl/gerenciador_sequencia_param_contador_tempo.sv - shared tick counter with terminal-count flag
module contador_tempo #(
    parameter int MAX = 5000,
    localparam int W  = $clog2(MAX)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limite,
    output logic         fim
);

    logic [W-1:0] conta_q;

    assign fim = (conta_q == limite);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conta_q <= '0;
        end else if (clr) begin
            conta_q <= '0;
        end else if (en && !fim) begin
            conta_q <= conta_q + 1'b1;
        end
    end

endmodule

// File: rtl/gerenciador_sequencia_param.sv
// rtl/gerenciador_sequencia_param.sv - record/show/check engine for the sequence game
module gerenciador_sequencia_param
    import gerenciador_sequencia_param_pkg::*;
#(
    parameter int N_BOTOES      = 4,
    parameter int PROFUNDIDADE  = 16,
    parameter int TICKS_ACESO   = 500,
    parameter int TICKS_APAGADO = 500,
    parameter int TICKS_TIMEOUT = 5000,
    localparam int AW           = $clog2(PROFUNDIDADE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          modo,
    input  logic                iniciar,
    input  logic [AW:0]         tamanho,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                ocupado,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [AW:0]         num_gravadas,
    output logic [3:0]          db_estado
);

    localparam int TMAX_MOSTRA = (TICKS_ACESO > TICKS_APAGADO) ? TICKS_ACESO : TICKS_APAGADO;
    localparam int TMAX        = (TMAX_MOSTRA > TICKS_TIMEOUT) ? TMAX_MOSTRA : TICKS_TIMEOUT;
    localparam int TW          = $clog2(TMAX);

    estado_t             estado_q;
    logic [N_BOTOES-1:0] mem [0:PROFUNDIDADE-1];
    logic [N_BOTOES-1:0] botoes_q, leds_q;
    logic [AW-1:0]       ptr_q;
    logic [AW:0]         num_q, idx_q, e_q, e_d, tam_ef, idx_inc;
    logic                acertou_q, errou_q, timeout_q;
    logic                jogada, valida, tempo_clr, tempo_fim;
    logic [TW-1:0]       tempo_limite;
    logic [N_BOTOES-1:0] esperado;

    // A play is the first cycle buttons go nonzero after reading all-released.
    always_comb begin
        jogada   = (botoes_q == '0) && (botoes != '0);
        valida   = $onehot(botoes);
        esperado = mem[idx_q[AW-1:0]];
        idx_inc  = idx_q + 1'b1;
        tam_ef   = (tamanho == '0) ? (AW+1)'(1) : tamanho;
        e_d      = (tam_ef < num_q) ? tam_ef : num_q;
        tempo_limite = TW'(TICKS_TIMEOUT - 1);
        tempo_clr    = 1'b1;
        case (estado_q)
            MOSTRA_ACESO: begin
                tempo_limite = TW'(TICKS_ACESO - 1);
                tempo_clr    = tempo_fim;
            end
            MOSTRA_APAGADO: begin
                tempo_limite = TW'(TICKS_APAGADO - 1);
                tempo_clr    = tempo_fim;
            end
            CONFERE: tempo_clr = tempo_fim | jogada;
            default: tempo_clr = 1'b1;
        endcase
    end

    contador_tempo #(.MAX(TMAX)) u_tempo (
        .clock  (clock),
        .reset  (reset),
        .clr    (tempo_clr),
        .en     (1'b1),
        .limite (tempo_limite),
        .fim    (tempo_fim)
    );

    always_ff @(posedge clock) begin
        if (estado_q == GRAVA && jogada && valida) begin
            mem[ptr_q] <= botoes;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            botoes_q  <= '0;
            leds_q    <= '0;
            ptr_q     <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            e_q       <= '0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            botoes_q <= botoes;
            case (estado_q)
                OCIOSO, FIM: begin
                    leds_q <= '0;
                    if (iniciar) begin
                        acertou_q <= 1'b0;
                        errou_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        idx_q     <= '0;
                        e_q       <= e_d;
                        case (modo)
                            MODO_GRAVAR: begin
                                estado_q <= GRAVA;
                                ptr_q    <= '0;
                                num_q    <= '0;
                            end
                            MODO_MOSTRAR: begin
                                if (e_d == '0) begin
                                    estado_q <= FIM;
                                end else begin
                                    estado_q <= MOSTRA_ACESO;
                                    leds_q   <= mem[0];
                                end
                            end
                            MODO_CONFERIR: begin
                                if (e_d == '0) begin
                                    estado_q  <= FIM;
                                    acertou_q <= 1'b1;
                                end else begin
                                    estado_q <= CONFERE;
                                end
                            end
                            default: estado_q <= OCIOSO;
                        endcase
                    end
                end
                GRAVA: begin
                    leds_q <= botoes;
                    if (jogada && valida) begin
                        ptr_q <= ptr_q + 1'b1;
                        num_q <= num_q + 1'b1;
                        if (num_q == (AW+1)'(PROFUNDIDADE - 1)) begin
                            estado_q <= FIM;
                            leds_q   <= '0;
                        end
                    end
                end
                MOSTRA_ACESO: begin
                    if (tempo_fim) begin
                        estado_q <= MOSTRA_APAGADO;
                        leds_q   <= '0;
                    end
                end
                MOSTRA_APAGADO: begin
                    if (tempo_fim) begin
                        idx_q <= idx_inc;
                        if (idx_inc == e_q) begin
                            estado_q <= FIM;
                        end else begin
                            estado_q <= MOSTRA_ACESO;
                            leds_q   <= mem[idx_inc[AW-1:0]];
                        end
                    end
                end
                CONFERE: begin
                    leds_q <= botoes;
                    // A play on the expiry cycle is judged; the timeout only fires without one.
                    if (jogada) begin
                        if (valida && botoes == esperado) begin
                            idx_q <= idx_inc;
                            if (idx_inc == e_q) begin
                                estado_q  <= FIM;
                                acertou_q <= 1'b1;
                                leds_q    <= '0;
                            end
                        end else begin
                            estado_q <= FIM;
                            errou_q  <= 1'b1;
                            leds_q   <= '0;
                        end
                    end else if (tempo_fim) begin
                        estado_q  <= FIM;
                        timeout_q <= 1'b1;
                        leds_q    <= '0;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign leds         = leds_q;
    assign ocupado      = (estado_q != OCIOSO) && (estado_q != FIM);
    assign pronto       = (estado_q == FIM);
    assign acertou      = acertou_q;
    assign errou        = errou_q;
    assign timeout      = timeout_q;
    assign num_gravadas = num_q;
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_gerenciador_sequencia_param.sv
// tb/tb_gerenciador_sequencia_param.sv - directed self-checking bench for gerenciador_sequencia_param
module tb_gerenciador_sequencia_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] modo = 2'b00;
    logic       iniciar = 1'b0;
    logic [3:0] tamanho = 4'd0;
    logic [3:0] botoes = 4'd0;
    logic [3:0] leds;
    logic       ocupado, pronto, acertou, errou, timeout;
    logic [3:0] num_gravadas;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_err = 0;

    gerenciador_sequencia_param #(
        .N_BOTOES(4), .PROFUNDIDADE(8), .TICKS_ACESO(3), .TICKS_APAGADO(2), .TICKS_TIMEOUT(10)
    ) dut (
        .clock(clock), .reset(reset), .modo(modo), .iniciar(iniciar), .tamanho(tamanho),
        .botoes(botoes), .leds(leds), .ocupado(ocupado), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .num_gravadas(num_gravadas), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] v);
        botoes = v;
        @(negedge clock);
        botoes = 4'd0;
        @(negedge clock);
    endtask

    task automatic start(input logic [1:0] m, input logic [3:0] t);
        modo    = m;
        tamanho = t;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic a, input logic e, input logic t);
        check_eq({tag, "_acertou"}, acertou, a);
        check_eq({tag, "_errou"}, errou, e);
        check_eq({tag, "_timeout"}, timeout, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp3[15];
        int seq8[8];
        exp3 = '{1, 1, 1, 0, 0, 2, 2, 2, 0, 0, 4, 4, 4, 0, 0};
        seq8 = '{1, 2, 4, 8, 1, 2, 4, 8};

        step(2);
        check_eq("rst_estado", db_estado, 4'h0);
        check_eq("rst_leds", leds, 4'h0);
        check_eq("rst_num", num_gravadas, 4'd0);
        check_eq("rst_ocupado", ocupado, 1'b0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1);

        start(2'b01, 4'd0);
        check_eq("grava_estado", db_estado, 4'h1);
        check_eq("grava_ocupado", ocupado, 1'b1);
        botoes = 4'd1;
        @(negedge clock);
        check_eq("grava_eco", leds, 4'd1);
        botoes = 4'd0;
        @(negedge clock);
        press(4'b0011);
        check_eq("grava_nao_onehot", num_gravadas, 4'd1);
        for (int k = 1; k < 8; k++) press(seq8[k][3:0]);
        check_eq("grava_num8", num_gravadas, 4'd8);
        check_eq("grava_fim", db_estado, 4'hF);
        check_eq("grava_pronto", pronto, 1'b1);
        press(4'd1);
        check_eq("grava_nona", num_gravadas, 4'd8);

        start(2'b10, 4'd3);
        for (int k = 0; k < 15; k++) begin
            check_eq($sformatf("mostra_leds_%0d", k), leds, exp3[k][3:0]);
            @(negedge clock);
        end
        check_eq("mostra_pronto", pronto, 1'b1);

        start(2'b10, 4'd0);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("mostra_t0_%0d", k), leds, exp3[k][3:0]);
            @(negedge clock);
        end
        check_eq("mostra_t0_pronto", pronto, 1'b1);

        start(2'b11, 4'd4);
        check_eq("conf_estado", db_estado, 4'h4);
        botoes = 4'd1;
        @(negedge clock);
        check_eq("conf_eco", leds, 4'd1);
        botoes = 4'd0;
        @(negedge clock);
        press(4'd2); press(4'd4); press(4'd8);
        check_flags("conf_ok", 1'b1, 1'b0, 1'b0);
        check_eq("conf_ok_fim", db_estado, 4'hF);

        start(2'b11, 4'd4);
        check_eq("conf_limpa", acertou, 1'b0);
        press(4'd1); press(4'd2);
        check_eq("conf_err_meio", errou, 1'b0);
        press(4'd8);
        check_flags("conf_err", 1'b0, 1'b1, 1'b0);
        check_eq("conf_err_fim", db_estado, 4'hF);

        start(2'b11, 4'd4);
        press(4'b0011);
        check_flags("conf_inval", 1'b0, 1'b1, 1'b0);

        start(2'b11, 4'd4);
        step(9);
        check_eq("tmo_antes", timeout, 1'b0);
        check_eq("tmo_antes_estado", db_estado, 4'h4);
        step(1);
        check_flags("tmo", 1'b0, 1'b0, 1'b1);
        check_eq("tmo_fim", db_estado, 4'hF);

        start(2'b11, 4'd4);
        step(9);
        botoes = 4'd1;
        @(negedge clock);
        check_eq("expira_timeout", timeout, 1'b0);
        check_eq("expira_estado", db_estado, 4'h4);
        botoes = 4'd0;
        @(negedge clock);
        press(4'd2); press(4'd4); press(4'd8);
        check_flags("expira_ok", 1'b1, 1'b0, 1'b0);

        start(2'b11, 4'd4);
        start(2'b10, 4'd3);
        check_eq("ignora_iniciar", db_estado, 4'h4);
        press(4'd1); press(4'd2); press(4'd4); press(4'd8);
        check_flags("ignora_ok", 1'b1, 1'b0, 1'b0);

        start(2'b11, 4'd12);
        for (int k = 0; k < 7; k++) press(seq8[k][3:0]);
        check_eq("e8_meio_estado", db_estado, 4'h4);
        check_eq("e8_meio_acertou", acertou, 1'b0);
        press(4'd8);
        check_flags("e8", 1'b1, 1'b0, 1'b0);

        start(2'b00, 4'd4);
        check_eq("modo0_estado", db_estado, 4'h0);
        check_eq("modo0_pronto", pronto, 1'b0);
        check_eq("modo0_acertou", acertou, 1'b0);

        start(2'b10, 4'd3);
        step(2);
        check_eq("rstm_antes", db_estado, 4'h2);
        #2 reset = 1'b0;
        #1;
        check_eq("rstm_estado", db_estado, 4'h0);
        check_eq("rstm_leds", leds, 4'h0);
        check_eq("rstm_num", num_gravadas, 4'd0);
        check_flags("rstm", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        start(2'b01, 4'd4);
        check_eq("vazio_grava", db_estado, 4'h1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        start(2'b11, 4'd4);
        check_flags("vazio", 1'b1, 1'b0, 1'b0);
        check_eq("vazio_fim", db_estado, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
